// File: rtl/dest_forward_unit_pkg.sv
// Shared encodings, widths and the stage payload for the destination forwarding unit.
package dest_forward_unit_pkg;

  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] dest;
    logic                 reg_write;
    logic                 mem_read;
  } stage_t;

  // A stage produces a usable result for src; register 0 never matches.
  function automatic logic dest_hit(input logic                 reg_write,
                                    input logic [REG_IDX_W-1:0] dest,
                                    input logic [REG_IDX_W-1:0] src);
    return reg_write && (dest != '0) && (dest == src);
  endfunction

endpackage

// File: rtl/dest_stage_reg.sv
// One pipeline destination stage; flush loads a bubble instead of the incoming payload.
module dest_stage_reg
  import dest_forward_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t stage_q;
  stage_t stage_d;

  always_comb begin
    stage_d = d_i;
    if (flush_i) stage_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign q_o = stage_q;

endmodule

// File: rtl/dest_forward_unit.sv
// EX->MEM->WB destination tracking, ALU operand forwarding, load-use stall and stall counter.
// Define WB_FORWARD_EN to generate the MEM/WB (2'b01) forwarding path.
module dest_forward_unit
  import dest_forward_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_IDX_W-1:0]   ex_dest,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic [REG_IDX_W-1:0]   ex_rs,
  input  logic [REG_IDX_W-1:0]   ex_rt,
  input  logic [REG_IDX_W-1:0]   id_rs,
  input  logic [REG_IDX_W-1:0]   id_rt,
  input  logic                   flush,
  input  logic                   cnt_clr,
  output logic [REG_IDX_W-1:0]   mem_dest,
  output logic                   mem_reg_write,
  output logic                   mem_mem_read,
  output logic [REG_IDX_W-1:0]   wb_dest,
  output logic                   wb_reg_write,
  output logic [1:0]             forward_a,
  output logic [1:0]             forward_b,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  stage_t   ex_stage;
  stage_t   mem_q;
  stage_t   wb_q;
  fwd_sel_e fwd_a_c;
  fwd_sel_e fwd_b_c;
  logic     stall_c;
  logic     unused_wb_mem_read;
  logic [STALL_CNT_W-1:0] cnt_q;
  logic [STALL_CNT_W-1:0] cnt_d;

  assign ex_stage = '{dest: ex_dest, reg_write: ex_reg_write, mem_read: ex_mem_read};

  dest_stage_reg u_mem_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .d_i     (ex_stage),
    .q_o     (mem_q)
  );

  dest_stage_reg u_wb_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (1'b0),
    .d_i     (mem_q),
    .q_o     (wb_q)
  );

  // MEM result has priority; the WB path only exists when enabled.
  always_comb begin
    fwd_a_c = FWD_NONE;
    fwd_b_c = FWD_NONE;
    if (dest_hit(mem_q.reg_write, mem_q.dest, ex_rs)) fwd_a_c = FWD_MEM;
`ifdef WB_FORWARD_EN
    else if (dest_hit(wb_q.reg_write, wb_q.dest, ex_rs)) fwd_a_c = FWD_WB;
`endif
    if (dest_hit(mem_q.reg_write, mem_q.dest, ex_rt)) fwd_b_c = FWD_MEM;
`ifdef WB_FORWARD_EN
    else if (dest_hit(wb_q.reg_write, wb_q.dest, ex_rt)) fwd_b_c = FWD_WB;
`endif
  end

  always_comb begin
    stall_c = ex_mem_read && (dest_hit(ex_reg_write, ex_dest, id_rs) ||
                              dest_hit(ex_reg_write, ex_dest, id_rt));
  end

  // Saturating count of stall cycles; clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                                     cnt_d = '0;
    else if (stall_c && (cnt_q != {STALL_CNT_W{1'b1}})) cnt_d = cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign mem_dest           = mem_q.dest;
  assign mem_reg_write      = mem_q.reg_write;
  assign mem_mem_read       = mem_q.mem_read;
  assign wb_dest            = wb_q.dest;
  assign wb_reg_write       = wb_q.reg_write;
  assign unused_wb_mem_read = wb_q.mem_read;
  assign forward_a          = fwd_a_c;
  assign forward_b          = fwd_b_c;
  assign stall              = stall_c;
  assign stall_cnt          = cnt_q;

endmodule

// File: tb/tb_dest_forward_unit.sv
// Scoreboard bench for dest_forward_unit: driver queues hand-computed expectations, monitor checks at negedge.
module tb_dest_forward_unit;

`ifdef WB_FORWARD_EN
  localparam logic [1:0] WB_EXP = 2'b01;
`else
  localparam logic [1:0] WB_EXP = 2'b00;
`endif

  typedef struct {
    string       name;
    logic [4:0]  md;
    logic        mrw;
    logic        mmr;
    logic [4:0]  wd;
    logic        wrw;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ex_dest = '0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rs = '0;
  logic [4:0]  ex_rt = '0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        flush = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [4:0]  mem_dest;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic [4:0]  wb_dest;
  logic        wb_reg_write;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        stall;
  logic [15:0] stall_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dest_forward_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_dest       (ex_dest),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .flush         (flush),
    .cnt_clr       (cnt_clr),
    .mem_dest      (mem_dest),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .wb_dest       (wb_dest),
    .wb_reg_write  (wb_reg_write),
    .forward_a     (forward_a),
    .forward_b     (forward_b),
    .stall         (stall),
    .stall_cnt     (stall_cnt)
  );

  task automatic check(input string nm, input string fld,
                       input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h (t=%0t)", nm, fld, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, "mem_dest",      16'(mem_dest),      16'(e.md));
      check(e.name, "mem_reg_write", 16'(mem_reg_write), 16'(e.mrw));
      check(e.name, "mem_mem_read",  16'(mem_mem_read),  16'(e.mmr));
      check(e.name, "wb_dest",       16'(wb_dest),       16'(e.wd));
      check(e.name, "wb_reg_write",  16'(wb_reg_write),  16'(e.wrw));
      check(e.name, "forward_a",     16'(forward_a),     16'(e.fa));
      check(e.name, "forward_b",     16'(forward_b),     16'(e.fb));
      check(e.name, "stall",         16'(stall),         16'(e.st));
      check(e.name, "stall_cnt",     stall_cnt,          e.cnt);
    end
  end

  // Apply one cycle of inputs just after the rising edge and queue the expected outputs for that cycle.
  task automatic step(input string nm, input logic rst,
                      input logic [4:0] d, input logic rw, input logic mr,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] irs, input logic [4:0] irt,
                      input logic fl, input logic clr,
                      input logic [4:0] e_md, input logic e_mrw, input logic e_mmr,
                      input logic [4:0] e_wd, input logic e_wrw,
                      input logic [1:0] e_fa, input logic [1:0] e_fb,
                      input logic e_st, input logic [15:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; ex_dest = d; ex_reg_write = rw; ex_mem_read = mr;
    ex_rs = rs; ex_rt = rt; id_rs = irs; id_rt = irt; flush = fl; cnt_clr = clr;
    e.name = nm; e.md = e_md; e.mrw = e_mrw; e.mmr = e_mmr; e.wd = e_wd; e.wrw = e_wrw;
    e.fa = e_fa; e.fb = e_fb; e.st = e_st; e.cnt = e_cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    //         name        rst d  rw mr rs rt irs irt fl clr | md mrw mmr wd wrw fa     fb     st cnt
    step("in_reset",   0, 8, 1, 0, 8, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("first_cap",  1, 8, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("alu_haz",    1, 9, 1, 0, 8, 0, 0, 0, 0, 0,   8, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0);
    step("pipe_adv",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   9, 1, 0, 8, 1, 2'b00, 2'b00, 0, 0);
    step("wb_haz",     1, 0, 0, 0, 0, 9, 0, 0, 0, 0,   0, 0, 0, 9, 1, 2'b00, WB_EXP, 0, 0);
    step("dual_a",     1, 5, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("dual_b",     1, 5, 1, 0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("dual_hit",   1, 0, 0, 0, 5, 5, 0, 0, 0, 0,   5, 1, 0, 5, 1, 2'b10, 2'b10, 0, 0);
    step("r0_a",       1, 0, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 5, 1, 2'b00, 2'b00, 0, 0);
    step("r0_fwd",     1, 4, 1, 1, 0, 0, 0, 4, 0, 0,   0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0);
    step("ld_use1",    1, 4, 1, 1, 0, 0, 0, 4, 0, 0,   4, 1, 1, 0, 1, 2'b00, 2'b00, 1, 1);
    step("ld_use2",    1, 4, 1, 1, 0, 0, 0, 4, 0, 0,   4, 1, 1, 4, 1, 2'b00, 2'b00, 1, 2);
    step("flush_stl",  1, 7, 1, 1, 0, 0, 0, 7, 1, 0,   4, 1, 1, 4, 1, 2'b00, 2'b00, 1, 3);
    step("flush_bub",  1, 0, 0, 0, 7, 0, 0, 0, 0, 0,   0, 0, 0, 4, 1, 2'b00, 2'b00, 0, 4);
    step("clr_stall",  1, 3, 1, 1, 0, 0, 3, 0, 0, 1,   0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 4);
    step("clr_done",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    step("flush_alu",  1, 7, 1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 3, 1, 2'b00, 2'b00, 0, 0);
    step("flush_fwd",  1, 0, 0, 0, 7, 7, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("wb_nf_a",    1, 6, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("wb_nf_b",    1, 0, 0, 0, 0, 0, 0, 0, 1, 0,   6, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("wb_nf_c",    1, 0, 0, 0, 6, 0, 0, 0, 0, 0,   0, 0, 0, 6, 1, WB_EXP, 2'b00, 0, 0);
    // Long load-use run: counter climbs to 16'hFFFE and then saturates over three more edges.
    step("sat_0",      1, 4, 1, 1, 0, 0, 0, 4, 0, 0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    step("sat_1",      1, 4, 1, 1, 0, 0, 0, 4, 0, 0,   4, 1, 1, 0, 0, 2'b00, 2'b00, 1, 1);
    for (int k = 2; k <= 65537; k++) begin
      logic [15:0] ec;
      ec = (k >= 65535) ? 16'hFFFF : 16'(k);
      step((k >= 65534) ? $sformatf("sat_%0d", k) : "sat_run",
           1, 4, 1, 1, 0, 0, 0, 4, 0, 0,   4, 1, 1, 4, 1, 2'b00, 2'b00, 1, ec);
    end
    // Asynchronous reset between edges with live MEM/WB matches on ex_rs/ex_rt.
    step("async_rst",  0, 4, 1, 0, 4, 4, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("rst_rel",    1, 4, 1, 0, 4, 4, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("post_rst",   1, 0, 0, 0, 4, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dest_forward_unit.md
DEST_FORWARD_UNIT -- requirements
Module: dest_forward_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, listed first: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 The block SHALL have these further inputs:
- ex_dest  input  5  destination register of the EX instruction (the RegDst-selected rt/rd).
- ex_reg_write  input  1  EX instruction writes the register file.
- ex_mem_read  input  1  EX instruction is a load.
- ex_rs, ex_rt  input  5 each  source operands of the EX instruction.
- id_rs, id_rt  input  5 each  source operands of the ID instruction.
- flush  input  1  squash the EX instruction as it enters MEM.
- cnt_clr  input  1  synchronous clear of the stall counter.
REQ-003 The block SHALL have these outputs:
- mem_dest  output  5, mem_reg_write  output  1, mem_mem_read  output  1  MEM-stage copies.
- wb_dest  output  5, wb_reg_write  output  1  WB-stage copies.
- forward_a, forward_b  output  2 each  ALU operand source selects.
- stall  output  1  load-use stall request to PC and IF/ID.
- stall_cnt  output  16  saturating stall-cycle count.

Function
REQ-004 On each rising clk edge with flush=0, mem_dest, mem_reg_write and mem_mem_read SHALL take ex_dest, ex_reg_write and ex_mem_read respectively, giving a latency of 1 cycle.
REQ-005 On a rising clk edge with flush=1, the MEM stage SHALL load a bubble: mem_dest=0, mem_reg_write=0, mem_mem_read=0.
REQ-006 On each rising clk edge, wb_dest and wb_reg_write SHALL take mem_dest and mem_reg_write, giving a latency of 2 cycles from EX.
REQ-007 flush SHALL NOT affect the WB stage.
REQ-008 forward_a SHALL be combinational, evaluated in this priority order:
- 2'b10 if mem_reg_write=1, mem_dest!=0 and mem_dest==ex_rs;
- else 2'b01 if wb_reg_write=1, wb_dest!=0 and wb_dest==ex_rs;
- else 2'b00.
REQ-009 forward_b SHALL follow the same rule as REQ-008 using ex_rt.
REQ-010 When MEM and WB both match, the MEM-stage source SHALL win.
REQ-011 Register 0 SHALL never cause forwarding or a stall.
REQ-012 stall SHALL be combinational: stall=1 iff ex_mem_read=1, ex_reg_write=1, ex_dest!=0, and (ex_dest==id_rs or ex_dest==id_rt).
REQ-013 stall SHALL NOT alter the stage registers; bubble insertion into ID/EX is done by the ID/EX register.
REQ-014 stall_cnt SHALL increment by 1 on each rising edge where stall=1 and cnt_clr=0.
REQ-015 stall_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-016 cnt_clr=1 SHALL zero stall_cnt on the next edge, overriding any increment in the same cycle.
REQ-017 When flush=1 and stall=1 occur in the same cycle, the flush bubble SHALL be applied and stall_cnt SHALL still count.

Reset
REQ-018 On rst_n=0, all stage registers and stall_cnt SHALL clear to 0 immediately, independent of clk.
REQ-019 As a consequence of REQ-018, forward_a and forward_b SHALL read 2'b00 during reset.
REQ-020 Reset asserted mid-operation SHALL discard in-flight destinations; no forwarding from pre-reset state is permitted after release.
REQ-021 The first capture after reset SHALL occur at the first rising clk edge with rst_n=1.

Configuration
REQ-022 Macro WB_FORWARD_EN defined: the MEM/WB forwarding path (2'b01) SHALL be generated as in REQ-008.
REQ-023 Macro WB_FORWARD_EN undefined: forward_a and forward_b SHALL never be 2'b01; a WB-stage match is resolved by the register file's write-first read and yields 2'b00.
REQ-024 With WB_FORWARD_EN undefined, the WB stage registers SHALL still exist and remain observable.

Structure
REQ-025 A shared package/header SHALL define:
- the forward-select encodings FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
- the register index width 5;
- the stall counter width 16.
REQ-026 One sub-module, dest_stage_reg, SHALL implement a single flushable destination stage register with asynchronous active-low reset.
REQ-027 dest_stage_reg SHALL be instantiated for both the MEM and WB stages, with flush tied to 0 for WB.

Verification
REQ-028 Scenario ALU hazard: ex_dest=8, ex_reg_write=1, then next cycle ex_rs=8 -> forward_a=2'b10.
REQ-029 Scenario WB hazard: ex_dest=9, ex_reg_write=1, two cycles later ex_rt=9 -> forward_b=2'b01 with WB_FORWARD_EN defined, 2'b00 without.
REQ-030 Scenario dual match: mem_dest=wb_dest=5, both reg_write=1, ex_rs=5 -> forward_a=2'b10.
REQ-031 Scenario load-use: ex_mem_read=1, ex_reg_write=1, ex_dest=4, id_rt=4 -> stall=1 and stall_cnt increments by 1 per edge; with ex_dest=0 -> stall=0.
REQ-032 Scenario flush: ex_dest=7, ex_reg_write=1, flush=1 -> next cycle mem_dest=0, mem_reg_write=0, and ex_rs=7 gives forward_a=2'b00.
REQ-033 Scenario counter saturation and reset: preload to 16'hFFFE, hold stall=1 for 3 edges -> stall_cnt=16'hFFFF; then drive rst_n=0 between edges -> all outputs 0 immediately.
